// File: rtl/lab_pd4_avm_pkg.sv
// Shared types and helpers for the PD4 Avalon-MM poller.
// Holds the FSM encoding and the derived-byte functions.
package lab_pd4_avm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    DECIDE,
    WR_D,
    WR_DD,
    WR_DEF
  } state_t;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  // Doubling modulo 256: the carry out of bit 7 is dropped.
  function automatic logic [7:0] dd_of(input logic [7:0] b);
    return {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] def_of(input logic [7:0] b);
    return ~b;
  endfunction

endpackage

// File: rtl/lab_pd4_avm_poller.sv
// Avalon-MM master that polls the data_d PIO and, on change,
// writes the byte, its double and its complement to three PIOs.
module lab_pd4_avm_poller
  import lab_pd4_avm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] SRC_ADDR = 8'h00,
  parameter logic [ADDR_W-1:0] D_ADDR = 8'h10,
  parameter logic [ADDR_W-1:0] DD_ADDR = 8'h20,
  parameter logic [ADDR_W-1:0] DEF_ADDR = 8'h30,
  parameter int POLL_DIV = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic [7:0]        last_data,
  output logic [15:0]       upd_cnt,
  output logic              err
);

  localparam logic [15:0] POLL_LAST = 16'(POLL_DIV - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [15:0]       poll_q, poll_d;
  logic [15:0]       to_q, to_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        sample_q, sample_d;
  logic [7:0]        last_q, last_d;
  logic              have_q, have_d;
  logic [15:0]       upd_q, upd_d;
  logic              err_q, err_d;
  logic              acc;

  // Only the low byte of read data carries the PIO value.
  logic unused_rdata;
  assign unused_rdata = ^avm_readdata[31:8];

  assign acc = (rd_q | wr_q) & ~avm_waitrequest;

  // Next-state and next-output logic for the poll/update sequence.
  always_comb begin
    state_d  = state_q;
    poll_d   = poll_q;
    to_d     = to_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sample_d = sample_q;
    last_d   = last_q;
    have_d   = have_q;
    upd_d    = upd_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (!enable) begin
          poll_d = '0;
        end else if (poll_q == POLL_LAST) begin
          poll_d  = '0;
          state_d = RD_REQ;
          rd_d    = 1'b1;
          addr_d  = SRC_ADDR;
        end else begin
          poll_d = poll_q + 16'd1;
        end
      end
      RD_REQ: begin
        if (acc) begin
          rd_d = 1'b0;
          to_d = '0;
          if (avm_readdatavalid) begin
            sample_d = avm_readdata[7:0];
            state_d  = DECIDE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          sample_d = avm_readdata[7:0];
          state_d  = DECIDE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      DECIDE: begin
        if (!have_q || sample_q != last_q) begin
          last_d  = sample_q;
          have_d  = 1'b1;
          state_d = WR_D;
          wr_d    = 1'b1;
          addr_d  = D_ADDR;
          wdata_d = sample_q;
        end else begin
          state_d = IDLE;
        end
      end
      WR_D: begin
        if (acc) begin
          state_d = WR_DD;
          addr_d  = DD_ADDR;
          wdata_d = dd_of(sample_q);
        end
      end
      WR_DD: begin
        if (acc) begin
          state_d = WR_DEF;
          addr_d  = DEF_ADDR;
          wdata_d = def_of(sample_q);
        end
      end
      WR_DEF: begin
        if (acc) begin
          state_d = IDLE;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          upd_d   = upd_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered bus outputs; reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      poll_q   <= '0;
      to_q     <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sample_q <= '0;
      last_q   <= '0;
      have_q   <= 1'b0;
      upd_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      poll_q   <= poll_d;
      to_q     <= to_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sample_q <= sample_d;
      last_q   <= last_d;
      have_q   <= have_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = {24'h0, wdata_q};
  assign avm_byteenable = BE_BYTE0;
  assign busy           = (state_q != IDLE);
  assign last_data      = last_q;
  assign upd_cnt        = upd_q;
  assign err            = err_q;

endmodule

// File: tb/tb_lab_pd4_avm_poller.sv
// Bench for the PD4 poller: bus slave, transaction scoreboard
// and per-cycle checks of idle status and stall stability.
module tb_lab_pd4_avm_poller;

  localparam int TIMEOUT = 64;
  localparam int POLL_DIV = 16;
  localparam logic [7:0] SRC = 8'h00;
  localparam logic [7:0] DA = 8'h10;
  localparam logic [7:0] DDA = 8'h20;
  localparam logic [7:0] DEFA = 8'h30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic [7:0]  last_data;
  logic [15:0] upd_cnt;
  logic        err;

  always #5 clk = ~clk;

  lab_pd4_avm_poller #(
    .ADDR_W(8), .SRC_ADDR(SRC), .D_ADDR(DA),
    .DD_ADDR(DDA), .DEF_ADDR(DEFA),
    .POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest),
    .busy(busy), .last_data(last_data),
    .upd_cnt(upd_cnt), .err(err)
  );

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t q[$];
  int checks = 0;
  int failures = 0;

  int         stall_n = 0;
  logic       rdv_en = 1'b1;
  logic [7:0] src_val = 8'h00;

  logic [7:0]  exp_last = 8'h00;
  logic [15:0] exp_upd = 16'h0;
  logic        exp_err = 1'b0;

  int          stall_seen = 0;
  logic        rd_pend = 1'b0;
  logic        prev_wait = 1'b0;
  logic        prev_req = 1'b0;
  logic [41:0] prev_bus = '0;
  int          tcnt = 0;
  logic        timing = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic cmd_t mk(input logic wr, input logic [7:0] a,
                              input logic [7:0] d);
    cmd_t c;
    c.wr = wr;
    c.addr = a;
    c.data = d;
    return c;
  endfunction

  task automatic push_rd();
    q.push_back(mk(1'b0, SRC, 8'h00));
  endtask

  task automatic push_upd(input int v);
    q.push_back(mk(1'b1, DA, 8'(v)));
    q.push_back(mk(1'b1, DDA, 8'((v * 2) % 256)));
    q.push_back(mk(1'b1, DEFA, 8'(255 - v)));
  endtask

  task automatic accept();
    cmd_t act;
    cmd_t e;
    act = mk(avm_write, avm_address,
             avm_write ? avm_writedata[7:0] : 8'h00);
    chk("be_upper", 64'({avm_byteenable, avm_writedata[31:8]}),
        64'({4'b0001, 24'h0}));
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_cmd actual=%0h required=none",
               act);
    end else begin
      e = q.pop_front();
      chk("cmd", 64'(act), 64'(e));
      chk("cmd_kind", 64'({avm_read, avm_write}),
          64'(e.wr ? 2'b01 : 2'b10));
      if (e.wr && e.addr == DA) exp_last = e.data;
      if (e.wr && e.addr == DEFA) exp_upd = exp_upd + 16'd1;
    end
  endtask

  // Slave, monitor and per-cycle model comparison.
  initial begin
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (reset) begin
        stall_seen = 0;
        rd_pend = 1'b0;
        prev_wait = 1'b0;
        prev_req = 1'b0;
        timing = 1'b0;
        avm_waitrequest = 1'b0;
      end else begin
        if (rd_pend) begin
          if (rdv_en) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = {24'hC3A596, src_val};
          end
          rd_pend = 1'b0;
        end
        if (timing) begin
          tcnt++;
          if (tcnt == TIMEOUT) begin
            chk("busy_pre_timeout", 64'(busy), 64'(1));
            chk("err_pre_timeout", 64'(err), 64'(exp_err));
          end else if (tcnt == TIMEOUT + 1) begin
            exp_err = 1'b1;
            timing = 1'b0;
            chk("err_at_timeout", 64'(err), 64'(1));
            chk("idle_at_timeout", 64'(busy), 64'(0));
          end
        end
        if (prev_wait && prev_req)
          chk("stall_hold",
              64'({avm_read, avm_write, avm_address, avm_writedata}),
              64'(prev_bus));
        if (avm_read || avm_write) begin
          if (stall_seen < stall_n) begin
            avm_waitrequest = 1'b1;
            stall_seen++;
          end else begin
            avm_waitrequest = 1'b0;
            stall_seen = 0;
            accept();
            if (avm_read) begin
              rd_pend = 1'b1;
              if (!rdv_en) begin
                timing = 1'b1;
                tcnt = 0;
              end
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
        end
        if (!busy)
          chk("idle_status", 64'({upd_cnt, last_data, err}),
              64'({exp_upd, exp_last, exp_err}));
        prev_wait = avm_waitrequest;
        prev_req = avm_read | avm_write;
        prev_bus = {avm_read, avm_write, avm_address, avm_writedata};
      end
    end
  end

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(q.size() == 0 && !busy) && n < budget);
    chk({nm, "_done"}, 64'(q.size() == 0 && !busy), 64'(1));
  endtask

  // Directed scenarios.
  initial begin
    logic found;
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_bus", 64'({avm_read, avm_write, avm_address, avm_writedata}),
        64'(0));
    chk("rst_status", 64'({busy, upd_cnt, last_data, err}), 64'(0));
    chk("rst_be", 64'(avm_byteenable), 64'(4'b0001));

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      chk("idle_quiet", 64'({busy, avm_read, avm_write}), 64'(0));
    end

    src_val = 8'h5A;
    push_rd();
    q.push_back(mk(1'b1, 8'h10, 8'h5A));
    q.push_back(mk(1'b1, 8'h20, 8'hB4));
    q.push_back(mk(1'b1, 8'h30, 8'hA5));
    enable = 1'b1;
    wait_done(200, "s2");
    chk("s2_upd", 64'(upd_cnt), 64'(1));
    chk("s2_last", 64'(last_data), 64'(8'h5A));

    push_rd();
    wait_done(200, "s3_same");
    chk("s3_same_upd", 64'(upd_cnt), 64'(1));
    src_val = 8'hFF;
    push_rd();
    q.push_back(mk(1'b1, 8'h10, 8'hFF));
    q.push_back(mk(1'b1, 8'h20, 8'hFE));
    q.push_back(mk(1'b1, 8'h30, 8'h00));
    wait_done(200, "s3_ff");
    chk("s3_upd", 64'(upd_cnt), 64'(2));
    chk("s3_last", 64'(last_data), 64'(8'hFF));

    stall_n = 3;
    src_val = 8'h5A;
    push_rd();
    push_upd(8'h5A);
    wait_done(300, "s4");
    chk("s4_upd", 64'(upd_cnt), 64'(3));
    stall_n = 0;

    rdv_en = 1'b0;
    push_rd();
    wait_done(300, "s5_to");
    chk("s5_err", 64'({err, busy}), 64'(2'b10));
    chk("s5_upd", 64'(upd_cnt), 64'(3));
    rdv_en = 1'b1;
    src_val = 8'h33;
    push_rd();
    push_upd(8'h33);
    wait_done(300, "s5_next");
    chk("s5_err_sticky", 64'(err), 64'(1));
    chk("s5_next_upd", 64'({upd_cnt, last_data}), 64'({16'd4, 8'h33}));

    stall_n = 3;
    src_val = 8'h77;
    push_rd();
    q.push_back(mk(1'b1, DA, 8'h77));
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      #1;
      if (avm_write && avm_address == DDA) found = 1'b1;
    end
    chk("s6_reach_dd", 64'(found), 64'(1));
    @(negedge clk);
    #1;
    chk("s6_stalled", 64'(avm_waitrequest), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("s6_rst", 64'({avm_write, avm_read, busy, upd_cnt,
                       last_data, err}), 64'(0));
    chk("s6_queue", 64'(q.size()), 64'(0));
    q.delete();
    exp_upd = 16'h0;
    exp_err = 1'b0;
    exp_last = 8'h00;
    @(negedge clk);
    #1 reset = 1'b0;
    push_rd();
    push_upd(8'h77);
    wait_done(400, "s6_after");
    chk("s6_after", 64'({upd_cnt, last_data, err}),
        64'({16'd1, 8'h77, 1'b0}));

    enable = 1'b0;
    stall_n = 0;
    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lab_pd4_avm_poller.md
Name: lab_pd4_avm_poller

Overview:
- Avalon-MM master (initiator) for the PD4 Platform Designer system. It drives the PIO slaves that the system exports.
- Periodically reads the 8-bit input PIO (data_d). When the value changes, it writes three derived bytes to the output PIOs d_slave, dd_slave and def_slave.
- Connects to the system as a custom master component on the same clock domain.

Parameters:
- ADDR_W, 8, Avalon byte-address width
- SRC_ADDR, 8'h00, base of the data_d input PIO (data register at offset 0)
- D_ADDR, 8'h10, base of the d_slave PIO
- DD_ADDR, 8'h20, base of the dd_slave PIO
- DEF_ADDR, 8'h30, base of the def_slave PIO
- POLL_DIV, 16, clk cycles between poll starts (≥2)
- TIMEOUT, 64, max cycles spent in RD_WAIT before an error

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- enable  in  1  polling allowed when 1
- avm_address  out  ADDR_W  Avalon address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data, byte in [7:0], upper bits 0
- avm_byteenable  out  4  constant 4'b0001
- avm_readdata  in  32  read data; only [7:0] is used
- avm_readdatavalid  in  1  read data valid
- avm_waitrequest  in  1  slave stall
- busy  out  1  FSM not in IDLE
- last_data  out  8  last captured data_d value
- upd_cnt  out  16  count of completed 3-write update sequences, wraps at 65535→0
- err  out  1  sticky read-timeout flag

Behaviour:
- Reset (synchronous, active-high) sets:
  - state IDLE; all outputs 0; avm_byteenable is always 4'b0001
  - poll counter 0, have_data 0
  - Reset asserted mid-transaction aborts at the next edge. No completion of in-flight writes.
- Registered outputs: avm_read, avm_write, avm_address and avm_writedata are flops set on state entry.
- Avalon command rules:
  - A command is accepted on an edge where (read|write) && !waitrequest.
  - Address, data and request are held stable while waitrequest=1.
  - The request deasserts the cycle after acceptance.
- States:
  - IDLE
    - If enable=1, increment the poll counter.
    - When the counter = POLL_DIV-1: clear it and go to RD_REQ (read=1, address=SRC_ADDR).
    - If enable=0, clear the counter.
  - RD_REQ
    - On acceptance, go to RD_WAIT and clear the timeout counter.
    - If readdatavalid=1 in the acceptance cycle, capture the data and go directly to DECIDE.
  - RD_WAIT
    - On readdatavalid: capture readdata[7:0] into a sample and go to DECIDE.
    - Otherwise increment the timeout counter. When it reaches TIMEOUT-1: set err=1 and go to IDLE with no writes.
  - DECIDE (one cycle)
    - If have_data=0 or sample≠last_data: last_data←sample, have_data←1, go to WR_D.
    - Otherwise go to IDLE.
  - WR_D: write sample to D_ADDR.
  - WR_DD: write (sample<<1)[7:0] to DD_ADDR (mod-256 doubling).
  - WR_DEF: write ~sample to DEF_ADDR.
  - Each write state advances on acceptance. Acceptance in WR_DEF increments upd_cnt and returns to IDLE.
- enable dropping mid-sequence does not abort; the current poll/update completes.
- err clears only on reset.
- Minimum poll-to-IDLE latency with zero wait states and readdatavalid one cycle after acceptance: RD_REQ 1 + RD_WAIT 1 + DECIDE 1 + 3 writes = 6 cycles.
- readdatavalid outside RD_REQ/RD_WAIT is ignored.

Decomposition:
- Package lab_pd4_avm_pkg holds:
  - state_t enum: IDLE, RD_REQ, RD_WAIT, DECIDE, WR_D, WR_DD, WR_DEF
  - BE_BYTE0 = 4'b0001
  - function dd_of(byte) = byte<<1 truncated to 8 bits
  - function def_of(byte) = ~byte
- No sub-module. Single FSM with the poll and timeout counters inline.

Test Plan:
1. Reset held 3 cycles, then released with enable=0 → all outputs 0, busy stays 0 for 100 cycles, no read/write.
2. enable=1, slave with no stalls returns 0x5A → one read at 0x00, then writes 0x5A@0x10, 0xB4@0x20, 0xA5@0x30 in order; upd_cnt=1, last_data=0x5A.
3. Next poll returns 0x5A again → read occurs, no writes, upd_cnt stays 1; then data 0xFF → writes 0xFF, 0xFE, 0x00, upd_cnt=2.
4. waitrequest held high 3 cycles on each command → address/data/request stable during the stall, each command accepted exactly once, final bus values identical to scenario 2.
5. Slave never asserts readdatavalid → err=1 exactly TIMEOUT cycles after read acceptance, FSM in IDLE, no writes; next poll proceeds and err stays 1.
6. Reset asserted during WR_DD with waitrequest=1 → next cycle avm_write=0, busy=0, upd_cnt=0, have_data=0; the first poll after reset writes all three values.
